button_debounce_pulse: RTL and testbench

- Conditions a raw, asynchronous push-button input into clean single-cycle event pulses and a debounced level.
- Sits directly upstream of the sticky-latch FSM; press_pulse drives that FSM's x input.
- Provides a two-flop synchronizer, a counter-based debounce state machine, and optional long-press detection.

---
 rtl/button_debounce_pulse.sv | 167 ++++++++++++++++
 tb/tb_button_debounce_pulse.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce_pulse
//  Purpose  : Turns a raw, bouncy, asynchronous push-button into a debounced
//             level plus single-cycle press / release / long-press pulses.
//             The input is passed through a two-flop synchronizer. A
//             counter-based FSM then accepts a new level only after
//             DEBOUNCE_CYCLES consecutive identical synchronized samples.
//  Ports    : clock_100Mhz  in   system clock, rising edge
//             reset         in   asynchronous active-low reset
//             btn_in        in   raw button, active-high, asynchronous
//             btn_level     out  debounced level (registered)
//             press_pulse   out  one-cycle pulse on an accepted press
//             release_pulse out  one-cycle pulse on an accepted release
//             long_pulse    out  one-cycle pulse once per press after
//                                LONG_CYCLES of hold time
//  Revision : 1.0  initial release
// ============================================================================
module button_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 100000000,
   parameter int CNT_W           = 27
) (
   input  logic clock_100Mhz,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   typedef enum logic [1:0] {
      S_IDLE         = 2'd0,
      S_WAIT_PRESS   = 2'd1,
      S_PRESSED      = 2'd2,
      S_WAIT_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_dcnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_hcnt_last = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_hcnt_max  = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

   logic             sync1_q;
   logic             sync_q;
   state_t           state_q,     state_d;
   logic [CNT_W-1:0] dcnt_q,      dcnt_d;
   logic [CNT_W-1:0] hcnt_q,      hcnt_d;
   logic             long_done_q, long_done_d;
   logic             level_q,     level_d;
   logic             press_q,     press_d;
   logic             release_q,   release_d;
   logic             long_q,      long_d;

   // Two-flop synchronizer; nothing downstream looks at btn_in directly.
   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         sync_q  <= sync1_q;
      end
   end

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         dcnt_q      <= '0;
         hcnt_q      <= '0;
         long_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         hcnt_q      <= hcnt_d;
         long_done_q <= long_done_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      long_done_d = long_done_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;

      // The hold timer runs in both held states, so a rejected release
      // glitch neither pauses nor restarts it.
      if (state_q == S_PRESSED || state_q == S_WAIT_RELEASE) begin
         if (hcnt_q != c_hcnt_max) begin
            hcnt_d = hcnt_q + c_one;
         end
         if (hcnt_q == c_hcnt_last && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (sync_q) begin
               state_d = S_WAIT_PRESS;
               dcnt_d  = c_one;
            end
         end
         S_WAIT_PRESS: begin
            if (!sync_q) begin
               state_d = S_IDLE;
               dcnt_d  = '0;
            end else if (dcnt_q == c_dcnt_last) begin
               state_d     = S_PRESSED;
               dcnt_d      = '0;
               press_d     = 1'b1;
               hcnt_d      = '0;
               long_done_d = 1'b0;
            end else begin
               dcnt_d = dcnt_q + c_one;
            end
         end
         S_PRESSED: begin
            if (!sync_q) begin
               state_d = S_WAIT_RELEASE;
               dcnt_d  = c_one;
            end
         end
         S_WAIT_RELEASE: begin
            if (sync_q) begin
               state_d = S_PRESSED;
               dcnt_d  = '0;
            end else if (dcnt_q == c_dcnt_last) begin
               state_d   = S_IDLE;
               dcnt_d    = '0;
               release_d = 1'b1;
               // The press is over; a long event landing on the same edge
               // is dropped so the two pulses never coincide.
               long_d    = 1'b0;
            end else begin
               dcnt_d = dcnt_q + c_one;
            end
         end
         default: begin
            state_d = S_IDLE;
            dcnt_d  = '0;
         end
      endcase

      level_d = (state_d == S_PRESSED) || (state_d == S_WAIT_RELEASE);
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_debounce_pulse
//  Purpose  : Self-checking bench for button_debounce_pulse with
//             DEBOUNCE_CYCLES=4, LONG_CYCLES=20. A run-length reference
//             model predicts every output each cycle; directed scenarios
//             additionally check latencies and pulse counts.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_debounce_pulse;
   localparam int D = 4;
   localparam int L = 20;
   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic btn   = 1'b0;
   logic lvl, pp, rp, lp;

   always #5 clk = ~clk;

   button_debounce_pulse #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_W(W)) dut (
      .clock_100Mhz (clk),
      .reset        (rst_n),
      .btn_in       (btn),
      .btn_level    (lvl),
      .press_pulse  (pp),
      .release_pulse(rp),
      .long_pulse   (lp)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: accepted level, run of opposite samples, hold time
   int m_s1, m_s2, m_acc, m_run, m_held, m_fired;
   int e_press, e_rel, e_long;

   int cyc = 0;
   int n_press = 0, n_rel = 0, n_long = 0;
   int last_press = -1000, last_rel = -1000, last_long = -1000;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0; m_held = 0; m_fired = 0;
      e_press = 0; e_rel = 0; e_long = 0;
   endtask

   task automatic model_edge();
      int s, was_held;
      if (!rst_n) begin
         model_reset();
         return;
      end
      s = m_s2;
      was_held = m_acc;
      e_press = 0; e_rel = 0; e_long = 0;
      if (s != m_acc) begin
         m_run++;
         if (m_run == D) begin
            m_run = 0;
            if (m_acc == 0) begin
               m_acc = 1; e_press = 1; m_held = 0; m_fired = 0;
            end else begin
               m_acc = 0; e_rel = 1;
            end
         end
      end else begin
         m_run = 0;
      end
      if (was_held != 0) begin
         if (m_held == L - 1 && m_fired == 0 && e_rel == 0) begin
            e_long = 1; m_fired = 1;
         end
         if (m_held < L) m_held++;
      end
      m_s2 = m_s1;
      m_s1 = int'(btn);
   endtask

   task automatic cmp_outputs();
      check_eq("btn_level",     32'(lvl), 32'(m_acc));
      check_eq("press_pulse",   32'(pp),  32'(e_press));
      check_eq("release_pulse", 32'(rp),  32'(e_rel));
      check_eq("long_pulse",    32'(lp),  32'(e_long));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      cmp_outputs();
      if (pp === 1'b1) begin n_press++; last_press = cyc; end
      if (rp === 1'b1) begin n_rel++;   last_rel   = cyc; end
      if (lp === 1'b1) begin n_long++;  last_long  = cyc; end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // reset asserted mid-cycle; outputs must drop before the next edge
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      cmp_outputs();
   endtask

   task automatic wait_press(input int budget);
      int p0;
      p0 = n_press;
      for (int i = 0; i < budget && n_press == p0; i++) tick();
   endtask

   int t0, p0, l0, r0;

   initial begin
      model_reset();
      // 1: reset held low with toggling input
      for (int i = 0; i < 6; i++) begin
         btn = ~btn;
         tick();
      end
      btn = 1'b0;
      rst_n = 1'b1;
      ticks(3);
      check_eq("quiet_pulses", 32'(n_press + n_rel + n_long), 32'd0);

      // 2 + 4: clean press, then held long enough for a long press
      btn = 1'b1; t0 = cyc; l0 = n_long;
      wait_press(20);
      check_eq("press_latency", 32'(last_press - t0), 32'd6);
      ticks(25);
      check_eq("long_count", 32'(n_long - l0), 32'd1);
      check_eq("long_offset", 32'(last_long - last_press), 32'd20);

      // 5: two-cycle glitch low, then a stable release
      r0 = n_rel;
      btn = 1'b0; ticks(2);
      btn = 1'b1; ticks(6);
      check_eq("glitch_no_release", 32'(n_rel - r0), 32'd0);
      btn = 1'b0; t0 = cyc;
      ticks(10);
      check_eq("release_count", 32'(n_rel - r0), 32'd1);
      check_eq("release_latency", 32'(last_rel - t0), 32'd6);

      // 3: bounce pattern then steady high
      p0 = n_press;
      btn = 1'b1; tick();
      btn = 1'b0; tick();
      btn = 1'b1; ticks(2);
      btn = 1'b0; tick();
      btn = 1'b1; t0 = cyc;
      ticks(10);
      check_eq("bounce_press_count", 32'(n_press - p0), 32'd1);
      check_eq("bounce_press_latency", 32'(last_press - t0), 32'd6);
      btn = 1'b0; ticks(10);

      // 6: async reset in WAIT_PRESS and again in PRESSED
      btn = 1'b1; ticks(4);
      async_reset();
      ticks(2);
      rst_n = 1'b1; t0 = cyc;
      wait_press(20);
      check_eq("reset_press_latency_a", 32'(last_press - t0), 32'd6);
      ticks(3);
      async_reset();
      ticks(2);
      rst_n = 1'b1; t0 = cyc;
      wait_press(20);
      check_eq("reset_press_latency_b", 32'(last_press - t0), 32'd6);
      btn = 1'b0; ticks(10);

      // randomized segments against the reference model
      for (int seg = 0; seg < 400; seg++) begin
         btn = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            async_reset();
            ticks($urandom_range(1, 2));
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 9) == 0) ticks(30);
         else ticks($urandom_range(1, 7));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
